key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Input-side counterpart to the LED drivers: samples the board's mechanical push-buttons on sys_clk (50 MHz) and filters contact bounce.
- Produces a clean per-key level plus single-cycle press, release and long-press event pulses.
- Sits between the raw key pins and the control logic that drives the LEDs.
- Keys are independent; all outputs are registered.

Parameters:
- NUM_KEYS, 4: number of key inputs.
- DEBOUNCE_CNT, 1_000_000: consecutive stable cycles required to accept a new level (20 ms at 50 MHz); simulation value 10.
- LONG_CNT, 50_000_000: cycles a key must be held, counted from the accepted press, before the long-press pulse fires (1 s); simulation value 50.
- KEY_ACTIVE_LOW, 1: 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous, active-low reset.
- key_in  input  NUM_KEYS  raw key pins; asynchronous to sys_clk.
- key_state  output  NUM_KEYS  debounced level; 1 = pressed, regardless of KEY_ACTIVE_LOW.
- key_press  output  NUM_KEYS  1-cycle pulse when key_state goes 0->1.
- key_release  output  NUM_KEYS  1-cycle pulse when key_state goes 1->0.
- key_long  output  NUM_KEYS  1-cycle pulse once per press when the hold reaches LONG_CNT.

Behaviour:
- Reset is asynchronous on sys_rst_n low:
  - All outputs go to 0.
  - Synchronizer flops go to the released level (1 if KEY_ACTIVE_LOW, else 0).
  - Debounce and hold counters clear.
- Synchronizer: each key passes through a 2-flop synchronizer, then is normalised to active-high (inverted when KEY_ACTIVE_LOW=1).
- Debounce counter:
  - Width is ceil(log2(DEBOUNCE_CNT)) bits.
  - If the synchronized level equals key_state, the counter is 0.
  - If it differs, the counter increments each cycle.
  - When the counter == DEBOUNCE_CNT-1 and the level still differs, key_state takes the new level and the counter returns to 0.
  - Any bounce back to the key_state level before that point clears the counter, so the glitch is rejected.
- Latency: a clean level change on key_in is reflected on key_state exactly 2 + DEBOUNCE_CNT cycles after the first sys_clk edge that captures it. The bench allows ±1 cycle for metastability alignment only.
- Event pulses:
  - key_press and key_release are registered and asserted in the same cycle key_state changes, for exactly 1 cycle.
  - The two can never assert together on the same key.
- Long-press hold counter:
  - Width is ceil(log2(LONG_CNT)) bits.
  - Clears on the key_press cycle, then increments every cycle while key_state=1.
  - When it reaches LONG_CNT-1, key_long pulses for 1 cycle and the counter saturates; there is no auto-repeat.
  - Clears when key_state=0.
- Release before LONG_CNT: key_long never fires; only key_release does.
- Release after a long press: key_release still fires normally.
- Multiple keys:
  - Keys are fully independent; simultaneous presses on several keys produce simultaneous pulses on the respective bits.
  - Per-key logic has no shared counters.
- Reset mid-operation: outputs drop to 0 immediately and no release pulse is generated. A key held through reset deassertion is re-accepted as a press after 2 + DEBOUNCE_CNT cycles.
- Parameter constraints: DEBOUNCE_CNT ≥ 2 and LONG_CNT ≥ 2, enforced by an elaboration-time check.

Decomposition:
- No shared package needed. A header holds the shared timing constants (CLK_FREQ_HZ = 50_000_000, DEBOUNCE_MS = 20, LONG_MS = 1000) so the LED blocks and this block agree on the clock rate.
- One natural sub-module, key_filter: a single key containing the synchronizer, debounce counter, hold counter and the three pulses.
- key_debounce is a generate loop of NUM_KEYS key_filter instances.

Test Plan (DEBOUNCE_CNT=10, LONG_CNT=50, KEY_ACTIVE_LOW=1):
- Reset with key_in=4'b1111, then release reset -> all outputs 0; outputs stay 0 for 100 cycles.
- key_in[0] driven 1->0 and held -> key_state[0]=1 and key_press[0] high for exactly 1 cycle, 12 cycles (±1) after the change; key_in[0] back to 1 -> key_release[0] 1 cycle pulse 12 cycles (±1) later.
- key_in[1] bounces (low 4 cycles, high 3, low 6, high 2), then settles low -> exactly one key_press[1], 12 cycles (±1) after final settle; no pulse during the bounce.
- key_in[2] held low 80 cycles -> key_press[2], then key_long[2] exactly 49 cycles after the key_press cycle, once only; on release, key_release[2] only.
- key_in[3] and key_in[0] pressed in the same cycle -> key_press[3] and key_press[0] in the same cycle; key_in[3] released after 30 held cycles -> key_release[3] and no key_long[3].
- sys_rst_n pulsed low while key_state[1]=1 and key held -> outputs 0 at once; after reset release, key_press[1] 12 cycles (±1) later; no key_release[1] at any point.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared timing constants for the key and LED blocks
package key_debounce_pkg;

  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int DEBOUNCE_MS = 20;
  localparam int LONG_MS     = 1000;

  localparam int DEBOUNCE_CNT_DEF = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int LONG_CNT_DEF     = (CLK_FREQ_HZ / 1000) * LONG_MS;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_filter.sv
// rtl/key_debounce_filter.sv - one key: synchronizer, debounce, hold counter, event pulses
module key_filter
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CNT   = 10,
  parameter int LONG_CNT       = 50,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DW = cnt_width(DEBOUNCE_CNT);
  localparam int LW = cnt_width(LONG_CNT);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CNT - 1);
  localparam logic [LW-1:0] HOLD_PRE  = LW'(LONG_CNT - 2);

  logic [1:0]    sync_q;
  logic          level;
  logic          accept;
  logic [DW-1:0] db_cnt;
  logic [LW-1:0] hold_cnt;

  assign level  = sync_q[1] ^ KEY_ACTIVE_LOW;
  assign accept = (level != key_state) && (db_cnt == DB_LAST);

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q      <= {2{KEY_ACTIVE_LOW}};
      db_cnt      <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_in};
      key_press   <= accept && level;
      key_release <= accept && !level;
      if ((level == key_state) || accept)
        db_cnt <= '0;
      else
        db_cnt <= db_cnt + DW'(1);
      if (accept)
        key_state <= level;
    end
  end

  // Saturating hold counter; the pulse is suppressed on the releasing cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt <= '0;
      key_long <= 1'b0;
    end else begin
      if (!key_state || accept)
        hold_cnt <= '0;
      else if (hold_cnt != HOLD_LAST)
        hold_cnt <= hold_cnt + LW'(1);
      key_long <= key_state && !accept && (hold_cnt == HOLD_PRE);
    end
  end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - debounced level and press/release/long-press pulses for NUM_KEYS keys
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int DEBOUNCE_CNT   = DEBOUNCE_CNT_DEF,
  parameter int LONG_CNT       = LONG_CNT_DEF,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  generate
    if (DEBOUNCE_CNT < 2 || LONG_CNT < 2) begin : g_param_check
      $error("key_debounce: DEBOUNCE_CNT and LONG_CNT must both be >= 2");
    end
  endgenerate

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_filter #(
      .DEBOUNCE_CNT  (DEBOUNCE_CNT),
      .LONG_CNT      (LONG_CNT),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_filter (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_in     (key_in[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce
module tb_key_debounce;

  localparam int NK = 4;
  localparam int DB = 10;
  localparam int LG = 50;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [NK-1:0] key_in    = '1;
  logic [NK-1:0] key_state, key_press, key_release, key_long;

  int passed = 0;
  int total  = 0;
  int press_cnt   [NK];
  int release_cnt [NK];
  int long_cnt    [NK];
  int overlap = 0;

  always #10 sys_clk = ~sys_clk;

  key_debounce #(
    .NUM_KEYS      (NK),
    .DEBOUNCE_CNT  (DB),
    .LONG_CNT      (LG),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always @(negedge sys_clk) begin
    for (int i = 0; i < NK; i++) begin
      if (key_press[i])   press_cnt[i]++;
      if (key_release[i]) release_cnt[i]++;
      if (key_long[i])    long_cnt[i]++;
      if (key_press[i] && key_release[i]) overlap++;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // n = number of posedges from the stimulus change up to the pulse, -1 on timeout
  task automatic wait_pulse(input int idx, input bit rel, input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (rel ? key_release[idx] : key_press[idx]) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    sys_rst_n = 1'b0;
    key_in    = 4'hF;
    repeat (3) tick();
    total++;
    if ({key_state, key_press, key_release, key_long} !== 16'h0)
      $display("FAIL reset_outputs: got %h, want 0000", {key_state, key_press, key_release, key_long});
    else passed++;
    sys_rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if ({key_state, key_press, key_release, key_long} !== 16'h0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL idle_outputs: %0d nonzero cycles, want 0", bad);
    else passed++;
  endtask

  task automatic test_press_release();
    int n;
    key_in[0] = 1'b0;
    wait_pulse(0, 1'b0, 30, n);
    total++;
    if (n < 11 || n > 13) $display("FAIL press0_latency: got %0d, want 12 +/-1", n);
    else passed++;
    total++;
    if (key_state[0] !== 1'b1) $display("FAIL press0_state: got %b, want 1", key_state[0]);
    else passed++;
    tick();
    total++;
    if ({key_state[0], key_press[0]} !== 2'b10)
      $display("FAIL press0_one_cycle: state/press got %b, want 10", {key_state[0], key_press[0]});
    else passed++;
    key_in[0] = 1'b1;
    wait_pulse(0, 1'b1, 30, n);
    total++;
    if (n < 11 || n > 13) $display("FAIL release0_latency: got %0d, want 12 +/-1", n);
    else passed++;
    tick();
    total++;
    if ({key_state[0], key_release[0]} !== 2'b00)
      $display("FAIL release0_one_cycle: state/release got %b, want 00", {key_state[0], key_release[0]});
    else passed++;
  endtask

  task automatic test_bounce();
    int n, p0;
    p0 = press_cnt[1];
    key_in[1] = 1'b0; repeat (4) tick();
    key_in[1] = 1'b1; repeat (3) tick();
    key_in[1] = 1'b0; repeat (6) tick();
    key_in[1] = 1'b1; repeat (2) tick();
    key_in[1] = 1'b0;
    wait_pulse(1, 1'b0, 30, n);
    total++;
    if (n < 11 || n > 13) $display("FAIL bounce_latency: got %0d, want 12 +/-1", n);
    else passed++;
    repeat (3) tick();
    total++;
    if (press_cnt[1] - p0 !== 1) $display("FAIL bounce_press_count: got %0d, want 1", press_cnt[1] - p0);
    else passed++;
  endtask

  task automatic test_long();
    int np, nl, n, l0, r0, p0;
    np = -1; nl = -1;
    l0 = long_cnt[2]; r0 = release_cnt[2]; p0 = press_cnt[2];
    key_in[2] = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (key_press[2]) np = c;
      if (key_long[2])  nl = c;
    end
    total++;
    if (np < 11 || np > 13) $display("FAIL long_press_latency: got %0d, want 12 +/-1", np);
    else passed++;
    total++;
    if (np < 0 || nl < 0 || nl - np !== 49)
      $display("FAIL long_delay: press at %0d long at %0d, want long 49 after press", np, nl);
    else passed++;
    key_in[2] = 1'b1;
    wait_pulse(2, 1'b1, 30, n);
    total++;
    if (n < 11 || n > 13) $display("FAIL long_release_latency: got %0d, want 12 +/-1", n);
    else passed++;
    repeat (60) tick();
    total++;
    if ({long_cnt[2] - l0, press_cnt[2] - p0, release_cnt[2] - r0} !== {32'd1, 32'd1, 32'd1})
      $display("FAIL long_counts: long/press/release got %0d/%0d/%0d, want 1/1/1",
               long_cnt[2] - l0, press_cnt[2] - p0, release_cnt[2] - r0);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int n, l3, r3;
    logic [1:0] got;
    n = -1; got = 2'b00;
    l3 = long_cnt[3]; r3 = release_cnt[3];
    key_in[3] = 1'b0;
    key_in[0] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (key_press[3] || key_press[0]) begin
        got = {key_press[3], key_press[0]};
        n = c;
        break;
      end
    end
    total++;
    if (got !== 2'b11 || n < 11 || n > 13)
      $display("FAIL simultaneous_press: got %b at %0d, want 11 at 12 +/-1", got, n);
    else passed++;
    if (n > 0) repeat (30 - n) tick();
    key_in[3] = 1'b1;
    repeat (70) tick();
    total++;
    if ({release_cnt[3] - r3, long_cnt[3] - l3} !== {32'd1, 32'd0})
      $display("FAIL short_hold: release/long got %0d/%0d, want 1/0",
               release_cnt[3] - r3, long_cnt[3] - l3);
    else passed++;
    key_in[0] = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_reset_mid();
    int n, r1;
    total++;
    if (key_state[1] !== 1'b1) $display("FAIL mid_precondition: key_state[1] got %b, want 1", key_state[1]);
    else passed++;
    r1 = release_cnt[1];
    tick();
    sys_rst_n = 1'b0;
    #1;
    total++;
    if ({key_state, key_press, key_release, key_long} !== 16'h0)
      $display("FAIL mid_reset_async: got %h, want 0000", {key_state, key_press, key_release, key_long});
    else passed++;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    wait_pulse(1, 1'b0, 30, n);
    total++;
    if (n < 11 || n > 13) $display("FAIL mid_repress_latency: got %0d, want 12 +/-1", n);
    else passed++;
    repeat (5) tick();
    total++;
    if (release_cnt[1] - r1 !== 0) $display("FAIL mid_no_release: got %0d, want 0", release_cnt[1] - r1);
    else passed++;
    total++;
    if (overlap !== 0) $display("FAIL press_release_overlap: got %0d, want 0", overlap);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_long();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
